// File: rtl/out_port_if.sv
// Output-port scheduler bus: input-port requests and output-side done
// in; grant, mux select, status and counters out.
//   master : the scheduler (drives grant/mux_sel/active/rr_ptr/pkt_cnt/timeout_err)
//   slave  : the surrounding switch logic (drives req/done)
interface out_port_if;
    logic [3:0]  req;
    logic        done;
    logic [3:0]  grant;
    logic [1:0]  mux_sel;
    logic        active;
    logic [1:0]  rr_ptr;
    logic [15:0] pkt_cnt;
    logic        timeout_err;

    modport master (
        input  req, done,
        output grant, mux_sel, active, rr_ptr, pkt_cnt, timeout_err
    );

    modport slave (
        output req, done,
        input  grant, mux_sel, active, rr_ptr, pkt_cnt, timeout_err
    );
endinterface

// File: rtl/out_port_scheduler.sv
// Round-robin scheduler for one switch output port (4 input ports).
// Ports: clk, rst (async, active-high), bus (out_port_if.master):
//   req[3:0], done in; grant[3:0], mux_sel[1:0], active, rr_ptr[1:0],
//   pkt_cnt[15:0], timeout_err out. All outputs registered.
// Optional busy watchdog: define OUT_PORT_SCHED_WDOG_EN; limit TIMEOUT.
module out_port_scheduler #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    out_port_if.master bus
);
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("out_port_scheduler: TIMEOUT must be 2..255");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  sel_q, sel_d;
    logic        act_q, act_d;
    logic [1:0]  rr_q, rr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;

    logic        found;
    logic [1:0]  win;
    logic        fin;
    logic        expire;
    logic        take;

    // Walk from the farthest offset down so the nearest requester
    // (starting at rr_q) is the last one written and wins.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = rr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_q + 2'(i);
            if (bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign fin  = (state_q == BUSY) && bus.done;
    // A transfer ends on done or watchdog abort; IDLE is always open.
    assign take = (state_q == IDLE) || fin || expire;

`ifdef OUT_PORT_SCHED_WDOG_EN
    logic [7:0] wd_q, wd_d;

    // done beats expiry when both land in the same cycle.
    assign expire = (state_q == BUSY) && !bus.done
                 && (wd_q == 8'(TIMEOUT - 1));

    always_comb begin
        wd_d = wd_q;
        if (take)
            wd_d = 8'd0;
        else if (state_q == BUSY)
            wd_d = wd_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_q <= 8'd0;
        else
            wd_q <= wd_d;
    end
`else
    assign expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'd0;
            sel_q   <= 2'd0;
            act_q   <= 1'b0;
            rr_q    <= 2'd0;
            cnt_q   <= 16'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            act_q   <= act_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        act_d   = act_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q + 16'(fin);
        terr_d  = expire;
        if (take) begin
            unique case (found)
                1'b1: begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    act_d   = 1'b1;
                    rr_d    = win + 2'd1;
                end
                default: begin
                    state_d = IDLE;
                    grant_d = 4'd0;
                    act_d   = 1'b0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.grant       = grant_q;
        bus.mux_sel     = sel_q;
        bus.active      = act_q;
        bus.rr_ptr      = rr_q;
        bus.pkt_cnt     = cnt_q;
        bus.timeout_err = terr_q;
    end
endmodule

// File: doc/out_port_scheduler.md
OUT_PORT_SCHEDULER -- requirements
Module: out_port_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 16, watchdog limit in cycles for BUSY without done; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  bit p = input port p has a packet for this output.
REQ-005 done  input  1  output side finished transmitting the current packet; pulse, sampled only in BUSY.
REQ-006 grant  output  4  one-hot grant to the input port being served; all zero when idle.
REQ-007 mux_sel  output  2  index of the granted port; drives the output data mux.
REQ-008 active  output  1  output is busy with a granted packet.
REQ-009 rr_ptr  output  2  current round-robin priority pointer.
REQ-010 pkt_cnt  output  16  number of completed transfers.
REQ-011 timeout_err  output  1  one-cycle pulse when the watchdog aborts a transfer; constant 0 when the watchdog is compiled out.

Function
REQ-012 States: IDLE, BUSY; all outputs are registered.
REQ-013 Search order starts at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3, all mod 4; the first port with req set wins.
REQ-014 IDLE with req!=0 at edge N: BUSY at N+1, with grant=onehot(w), mux_sel=w, active=1, rr_ptr=(w+1) mod 4.
REQ-015 IDLE with req==0: stay IDLE; grant=0, active=0, and mux_sel and rr_ptr hold their values.
REQ-016 In BUSY, grant, mux_sel and active hold stable until done=1 or watchdog expiry, even if req[w] drops (the transfer is committed).
REQ-017 BUSY with done=1 and req!=0: pkt_cnt+1, and the next winner is chosen with the already-updated rr_ptr; the new grant is valid the next cycle with no idle bubble.
REQ-018 BUSY with done=1 and req==0: pkt_cnt+1, go to IDLE; grant=0 and active=0 the next cycle.
REQ-019 When the current port is the only requester, it may be regranted back-to-back.
REQ-020 pkt_cnt wraps from 0xFFFF to 0x0000 without any flag.
REQ-021 grant is always zero or one-hot; grant[mux_sel]==active at all times.
REQ-022 A req bit that drops before it is granted is ignored; no request is latched.
REQ-023 rr_ptr changes only when a grant is issued; with continuous requesters the service order is strictly rotating, and no port waits more than 3 transfers.

Reset
REQ-024 While rst=1 and asynchronously on its assertion: state=IDLE, grant=0, mux_sel=0, active=0, rr_ptr=0, pkt_cnt=0, timeout_err=0, watchdog=0.
REQ-025 Reset mid-transfer aborts the transfer without incrementing pkt_cnt.
REQ-026 After release, the first grant can occur on the first rising edge at which rst=0 and req!=0.

Configuration
REQ-027 Macro OUT_PORT_SCHED_WDOG_EN defined: an 8-bit counter clears on entering BUSY and increments on each BUSY cycle with done=0.
REQ-028 When that counter reaches TIMEOUT-1 with done=0, the transfer is aborted as if done=1 but pkt_cnt is not incremented; timeout_err pulses for 1 cycle coincident with the grant change.
REQ-029 done and expiry in the same cycle: done wins; normal completion, no timeout_err.
REQ-030 Macro undefined: no watchdog logic, timeout_err tied 0, and BUSY persists indefinitely until done.

Verification
REQ-031 Reset, then req=4'b1010 for 1 cycle -> next cycle grant=4'b0010, mux_sel=1, active=1, rr_ptr=2; the grant holds after req drops until done.
REQ-032 req=4'b1111 held with done pulsed each BUSY cycle -> grant order is ports 0,1,2,3,0 with no idle cycles, and pkt_cnt=5 after five dones.
REQ-033 Port 2 is the only requester with done every cycle -> grant=4'b0100 continuously and rr_ptr=3 throughout.
REQ-034 rst asserted asynchronously mid-BUSY (pkt_cnt=7) -> immediately grant=0, active=0, rr_ptr=0, pkt_cnt=0.
REQ-035 With WDOG_EN, TIMEOUT=16, grant port 3 and never assert done -> 16 cycles after the grant, timeout_err=1 for 1 cycle, grant=0, and pkt_cnt is unchanged.
REQ-036 pkt_cnt preloaded to 0xFFFF via 65535 transfers, one more done -> pkt_cnt=0x0000.
